// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: ATM keypad capture of card number and PIN with BCD-to-binary conversion.
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int CARD_DIGITS    = 8,
    parameter int PIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        session_end,
    output logic        key_ready,
    output logic        start,
    output logic [31:0] cardnumber,
    output logic        card_valid,
    output logic [19:0] pin,
    output logic        pin_valid,
    output logic        entry_err,
    output logic        timeout
);
    localparam int MAXD = CARD_DIGITS > PIN_DIGITS ? CARD_DIGITS : PIN_DIGITS;
    localparam int W    = 4 * MAXD;

    if (CARD_DIGITS < 1 || CARD_DIGITS > 9 || PIN_DIGITS < 1 || PIN_DIGITS > 6 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("atm_keypad_entry: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, CARD, CONV_C, PIN, CONV_P, DONE} state_t;
    state_t      state_q, state_d;
    logic [W-1:0] reg_q, reg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d, card_q, card_d, acc_nxt;
    logic [19:0] pin_q, pin_d;
    logic        cv_q, cv_d, pv_q, pv_d;
    logic        in_entry, acc_key, is_dig, full, tmo;
    logic [3:0]  lim, dig;

    assign key_ready  = state_q == IDLE || state_q == CARD || state_q == PIN;
    assign in_entry   = state_q == CARD || state_q == PIN;
    assign acc_key    = key_valid & key_ready & ~session_end;
    assign is_dig     = key_code <= 4'd9;
    assign lim        = state_q == PIN ? 4'(PIN_DIGITS) : 4'(CARD_DIGITS);
    assign full       = cnt_q == lim;
    // Conversion shifts the register left, so the MSB digit always sits at a fixed nibble.
    assign dig        = state_q == CONV_P ? reg_q[4*PIN_DIGITS-1 -: 4] : reg_q[4*CARD_DIGITS-1 -: 4];
    assign acc_nxt    = acc_q * 32'd10 + 32'(dig);
    assign start      = rst_n & acc_key & (state_q == IDLE) & is_dig;
    assign entry_err  = acc_key & in_entry & ((is_dig & full) | (key_code == 4'hB & cnt_q == 4'd0) | (key_code == 4'hE & ~full));
    assign timeout    = tmo;
    assign cardnumber = card_q;
    assign pin        = pin_q;
    assign card_valid = cv_q;
    assign pin_valid  = pv_q;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    assign tmo     = in_entry & ~acc_key & ~session_end & (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign timer_d = (in_entry & ~acc_key & ~session_end & ~tmo) ? timer_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        card_d  = card_q;
        pin_d   = pin_q;
        cv_d    = 1'b0;
        pv_d    = 1'b0;
        if (session_end || tmo) begin
            state_d = IDLE;
            reg_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    reg_d   = W'(key_code);
                    cnt_d   = 4'd1;
                    state_d = CARD;
                end
                CARD, PIN: if (acc_key) begin
                    if (is_dig && !full) begin
                        reg_d = (reg_q << 4) | W'(key_code);
                        cnt_d = cnt_q + 4'd1;
                    end else if (key_code == 4'hA) begin
                        reg_d = '0;
                        cnt_d = '0;
                    end else if (key_code == 4'hB && cnt_q != 4'd0) begin
                        reg_d = reg_q >> 4;
                        cnt_d = cnt_q - 4'd1;
                    end else if (key_code == 4'hE && full) begin
                        state_d = state_q == CARD ? CONV_C : CONV_P;
                        acc_d   = '0;
                    end
                end
                CONV_C, CONV_P: begin
                    reg_d = reg_q << 4;
                    cnt_d = cnt_q - 4'd1;
                    acc_d = acc_nxt;
                    if (cnt_q == 4'd1) begin
                        reg_d   = '0;
                        acc_d   = '0;
                        state_d = state_q == CONV_C ? PIN : DONE;
                        card_d  = state_q == CONV_C ? acc_nxt : card_q;
                        pin_d   = state_q == CONV_P ? acc_nxt[19:0] : pin_q;
                        cv_d    = state_q == CONV_C;
                        pv_d    = state_q == CONV_P;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            card_q  <= '0;
            pin_q   <= '0;
            cv_q    <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            card_q  <= card_d;
            pin_q   <= pin_d;
            cv_q    <= cv_d;
            pv_q    <= pv_d;
        end
    end
endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb_atm_keypad_entry: directed and random keypad traffic checked against a digit-list reference model.
module tb_atm_keypad_entry;
    localparam int CD = 8;
    localparam int PD = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        session_end = 1'b0;
    logic        key_ready, start, card_valid, pin_valid, entry_err, timeout;
    logic [31:0] cardnumber;
    logic [19:0] pin;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 card, 2 card conversion, 3 pin, 4 pin conversion, 5 done.
    int          ph = 0;
    int          q[$];
    int          left = 0;
    int          idle = 0;
    logic [31:0] m_card = '0;
    logic [19:0] m_pin = '0;
    bit          m_cv = 0;
    bit          m_pv = 0;

    atm_keypad_entry #(.CARD_DIGITS(CD), .PIN_DIGITS(PD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .session_end(session_end), .key_ready(key_ready), .start(start),
        .cardnumber(cardnumber), .card_valid(card_valid), .pin(pin),
        .pin_valid(pin_valid), .entry_err(entry_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit kv, input int kc, input bit se);
        bit rdy, a, dig, e_start, e_err, e_to;
        int lim, n;
        logic [31:0] v;
        @(negedge clk);
        key_valid   = kv;
        key_code    = 4'(kc);
        session_end = se;
        #1;
        rdy     = ph == 0 || ph == 1 || ph == 3;
        a       = rdy && kv && !se;
        dig     = kc <= 9;
        lim     = ph == 3 ? PD : CD;
        n       = q.size();
        e_start = ph == 0 && a && dig;
        e_err   = (ph == 1 || ph == 3) && a && ((dig && n == lim) || (kc == 11 && n == 0) || (kc == 14 && n != lim));
        e_to    = 0;
`ifdef KEYPAD_TIMEOUT_EN
        e_to = (ph == 1 || ph == 3) && !a && !se && idle + 1 == TO;
`endif
        check("key_ready", 32'(key_ready), 32'(rdy));
        check("start", 32'(start), 32'(e_start));
        check("entry_err", 32'(entry_err), 32'(e_err));
        check("timeout", 32'(timeout), 32'(e_to));
        check("card_valid", 32'(card_valid), 32'(m_cv));
        check("cardnumber", cardnumber, m_card);
        check("pin_valid", 32'(pin_valid), 32'(m_pv));
        check("pin", 32'(pin), 32'(m_pin));
        @(posedge clk);
        m_cv = 0;
        m_pv = 0;
        if (se || e_to) begin
            ph = 0;
            q.delete();
            idle = 0;
        end else if (ph == 0) begin
            if (e_start) begin
                q.delete();
                q.push_back(kc);
                ph = 1;
                idle = 0;
            end
        end else if (ph == 1 || ph == 3) begin
            if (a) begin
                idle = 0;
                if (dig && n < lim) q.push_back(kc);
                else if (kc == 10) q.delete();
                else if (kc == 11 && n > 0) void'(q.pop_back());
                else if (kc == 14 && n == lim) begin
                    ph++;
                    left = lim;
                end
            end else idle++;
        end else if (ph == 2 || ph == 4) begin
            left--;
            if (left == 0) begin
                v = 0;
                foreach (q[i]) v = v * 10 + 32'(q[i]);
                if (ph == 2) begin
                    m_card = v;
                    m_cv = 1;
                    ph = 3;
                end else begin
                    m_pin = v[19:0];
                    m_pv = 1;
                    ph = 5;
                end
                q.delete();
                idle = 0;
            end
        end
    endtask

    task automatic key(input int kc);
        step(1, kc, 0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_valid = 1'b0;
        session_end = 1'b0;
        #1;
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_card_valid", 32'(card_valid), 32'd0);
        check("rst_cardnumber", cardnumber, 32'd0);
        check("rst_pin_valid", 32'(pin_valid), 32'd0);
        check("rst_pin", 32'(pin), 32'd0);
        check("rst_entry_err", 32'(entry_err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ph = 0;
        q.delete();
        idle = 0;
        m_card = '0;
        m_pin = '0;
        m_cv = 0;
        m_pv = 0;
    endtask

    initial begin
        int r, kc;
        int codes[6];
        codes = '{10, 11, 14, 12, 13, 15};
        do_reset();
        // Full card and PIN session.
        foreach (codes[i]) key(codes[i]);
        for (int i = 0; i < 8; i++) key(i < 4 ? 1 : 2);
        key(14);
        wait_cycles(9);
        check("card_11112222", cardnumber, 32'd11112222);
        key(5); key(4); key(3); key(2); key(14);
        wait_cycles(5);
        check("pin_5432", 32'(pin), 32'd5432);
        check("done_not_ready", 32'(key_ready), 32'd0);
        step(0, 0, 1);
        wait_cycles(1);
        // Short ENTER and backspace underflow.
        key(2); key(2); key(2); key(14);
        for (int i = 0; i < 4; i++) key(11);
        step(1, 5, 1);
        // Ninth digit rejected.
        for (int i = 1; i <= 9; i++) key(i);
        key(14);
        wait_cycles(9);
        check("card_first8", cardnumber, 32'd12345678);
        step(0, 0, 1);
        // Reset during card conversion.
        for (int i = 0; i < 8; i++) key(9 - i);
        key(14);
        wait_cycles(3);
        do_reset();
        wait_cycles(10);
        check("abort_card", cardnumber, 32'd0);
        // Inactivity: one digit, then idle past the timeout window.
        key(3);
        wait_cycles(TO + 2);
        key(14);
        step(0, 0, 1);
        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            r  = $urandom_range(0, 99);
            kc = r < 70 ? r % 10 : codes[r % 6];
            step($urandom_range(0, 3) != 0, kc, $urandom_range(0, 199) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 Parameter CARD_DIGITS, default 8: decimal digits in a card number, range 1..9.
REQ-002 Parameter PIN_DIGITS, default 4: decimal digits in a PIN, range 1..6.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: number of idle clk cycles before an abandoned entry is dropped.
REQ-004 clk  input  1: single clock, rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 key_valid  input  1: key_code is valid this cycle; sampled only when key_ready=1.
REQ-007 key_code  input  4: 0-9 digit, 0xA CLEAR, 0xB BACKSPACE, 0xE ENTER; other codes are ignored.
REQ-008 session_end  input  1: one-cycle pulse from the downstream controller; ends the session.
REQ-009 key_ready  output  1: block accepts a key this cycle.
REQ-010 start  output  1: one-cycle pulse on the first digit of a session.
REQ-011 cardnumber  output  32: binary value of the entered card digits.
REQ-012 card_valid  output  1: one-cycle pulse when cardnumber is updated.
REQ-013 pin  output  20: binary value of the entered PIN digits.
REQ-014 pin_valid  output  1: one-cycle pulse when pin is updated.
REQ-015 entry_err  output  1: one-cycle pulse on a rejected key.
REQ-016 timeout  output  1: one-cycle pulse when the inactivity timer expires.

Function
REQ-017 The FSM SHALL have the states IDLE, CARD, CONV_C, PIN, CONV_P and DONE.
REQ-018 Digits SHALL be held as BCD in a shift register with a digit counter: a digit shifts in at the LSB nibble and increments the counter; BACKSPACE shifts right and decrements the counter; CLEAR zeroes the register and the counter.
REQ-019 IDLE: a digit SHALL load as the first card digit, pulse start in the same cycle it is accepted, and go to CARD; all non-digit keys SHALL be ignored.
REQ-020 CARD/PIN: a digit arriving with counter==limit SHALL pulse entry_err and leave the register unchanged.
REQ-021 CARD/PIN: BACKSPACE with counter==0 SHALL pulse entry_err.
REQ-022 CARD/PIN: ENTER with counter!=limit SHALL pulse entry_err and keep the state.
REQ-023 CARD/PIN: ENTER with counter==limit SHALL go to CONV_C or CONV_P respectively.
REQ-024 CONV_x: acc=acc*10+digit SHALL be computed MSB digit first, one digit per cycle, for CARD_DIGITS or PIN_DIGITS cycles; key_ready SHALL be 0 throughout.
REQ-025 Latency: with ENTER sampled at edge t, card_valid SHALL be high for the cycle after edge t+CARD_DIGITS, cardnumber SHALL be updated at that edge, and the next state SHALL be PIN with its counter and register cleared; the PIN path is identical with PIN_DIGITS, pin_valid, and next state DONE.
REQ-026 Arithmetic: the accumulator SHALL be 32 bits; the result SHALL be zero-extended to cardnumber or truncated to 20 bits for pin (9999 and 999999 both fit).
REQ-027 cardnumber and pin SHALL hold their values until the next conversion or reset; they SHALL NOT be cleared by session_end.
REQ-028 DONE: key_ready SHALL be 0; session_end SHALL return the FSM to IDLE.
REQ-029 session_end in any state SHALL return the FSM to IDLE and clear the register and counter; if session_end and key_valid arrive together, session_end wins and the key is dropped.
REQ-030 key_ready SHALL be 1 in IDLE, CARD and PIN, and 0 otherwise.

Reset
REQ-031 While rst_n=0: state=IDLE; all outputs 0 except key_ready=1; register, counter, accumulator and timer = 0.
REQ-032 Reset asserted mid-entry or mid-conversion SHALL abort the operation with no valid pulse.

Configuration
REQ-033 With KEYPAD_TIMEOUT_EN defined: an idle counter SHALL run in CARD and PIN, clear on every accepted key, and on reaching TIMEOUT_CYCLES SHALL pulse timeout and return the FSM to IDLE with the register cleared.
REQ-034 Without KEYPAD_TIMEOUT_EN: no timer logic SHALL exist, timeout SHALL be tied to 0, and entry SHALL wait indefinitely.

Verification
REQ-035 Keys 1,1,1,1,2,2,2,2,ENTER -> start on the first key; card_valid 8 cycles after ENTER; cardnumber=11112222; state PIN.
REQ-036 Then keys 5,4,3,2,ENTER -> pin_valid 4 cycles after ENTER; pin=5432; key_ready=0 in DONE; session_end -> IDLE, key_ready=1.
REQ-037 Card entry 2,2,2,ENTER -> entry_err pulse, state stays CARD; then BACKSPACE x3 and one further BACKSPACE -> the 4th BACKSPACE pulses entry_err.
REQ-038 Nine digits in CARD -> entry_err on the 9th digit; cardnumber after ENTER equals the first 8 digits.
REQ-039 rst_n low during CONV_C -> no card_valid; cardnumber=0; state IDLE.
REQ-040 KEYPAD_TIMEOUT_EN with TIMEOUT_CYCLES=20: one digit, then 20 idle cycles -> timeout pulse and IDLE; the same stimulus without the macro -> stays in CARD.
